// File: rtl/lp_fifo_drain_pkg.sv
// Shared types for the FIFO burst drain controller.
// Holds the FSM state enum and the timer width helper.
package lp_fifo_drain_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DRAIN = 2'd2
   } state_e;

   // ceil(log2(timeout+1)), never below 1
   function automatic int timer_width(input int timeout);
      int w;
      w = 1;
      while ((1 << w) < (timeout + 1)) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/lp_fifo_drain_timer.sv
// Saturating idle counter for the burst drain timeout flush.
// Only instantiated when LP_FIFO_BURST_DRAIN_TIMEOUT_EN is defined.
module lp_fifo_drain_timer
   import lp_fifo_drain_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int TW = timer_width(TIMEOUT);
   localparam logic [TW-1:0] MAX = TW'(TIMEOUT - 1);

   logic [TW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == MAX);

endmodule

// File: rtl/lp_fifo_burst_drain.sv
// Burst drain controller downstream of the low-power dataflow FIFO.
// Define LP_FIFO_BURST_DRAIN_TIMEOUT_EN to enable the partial-burst timeout flush.
module lp_fifo_burst_drain
   import lp_fifo_drain_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int CNT_WIDTH = 4,
   parameter int BURST_LEN = 4,
   parameter int TIMEOUT   = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WIDTH-1:0]     fifo_data_out,
   input  logic [CNT_WIDTH-1:0] fifo_word_cnt,
   input  logic                 fifo_empty,
   output logic                 fifo_pop_n,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [WIDTH-1:0]     m_data,
   output logic                 m_last,
   output logic                 busy
);

   localparam logic [CNT_WIDTH-1:0] BL  = CNT_WIDTH'(BURST_LEN);
   localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

   if ((BURST_LEN < 1) || (BURST_LEN > (1 << CNT_WIDTH) - 1) ||
       (TIMEOUT < 1)) begin : g_bad_cfg
      $error("lp_fifo_burst_drain: illegal parameter set");
   end

   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] remain_q, remain_d;
   logic [WIDTH-1:0]     m_data_q, m_data_d;
   logic                 m_valid_q, m_valid_d;
   logic                 m_last_q, m_last_d;
   logic                 busy_q, busy_d;

   logic                 start;
   logic                 pop;
   logic                 out_free;
   logic                 accept;
   logic [CNT_WIDTH-1:0] start_len;

   assign accept   = m_valid_q && m_ready;
   assign out_free = !m_valid_q || m_ready;
   assign pop      = rst_n && (state_q == BURST) &&
                     !fifo_empty && out_free;
   assign fifo_pop_n = !pop;

`ifdef LP_FIFO_BURST_DRAIN_TIMEOUT_EN
   logic tmr_clr;
   logic tmr_expired;

   // Timer only runs while idle and holding residual words
   assign tmr_clr = (state_q != IDLE) || fifo_empty || start;

   lp_fifo_drain_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (tmr_clr),
      .en      (!fifo_empty),
      .expired (tmr_expired)
   );

   assign start = (state_q == IDLE) &&
                  ((fifo_word_cnt >= BL) ||
                   (tmr_expired && !fifo_empty));
   assign start_len = (fifo_word_cnt < BL) ? fifo_word_cnt : BL;
`else
   assign start     = (state_q == IDLE) && (fifo_word_cnt >= BL);
   assign start_len = BL;
`endif

   always_comb begin
      state_d   = state_q;
      remain_d  = remain_q;
      m_data_d  = m_data_q;
      m_valid_d = m_valid_q;
      m_last_d  = m_last_q;
      if (accept) begin
         m_valid_d = 1'b0;
         m_last_d  = 1'b0;
      end
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = BURST;
               remain_d = start_len;
            end
         end
         BURST: begin
            if (pop) begin
               m_data_d  = fifo_data_out;
               m_valid_d = 1'b1;
               m_last_d  = (remain_q == ONE);
               remain_d  = remain_q - ONE;
               if (remain_q == ONE) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (accept) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         remain_q  <= '0;
         m_data_q  <= '0;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         remain_q  <= remain_d;
         m_data_q  <= m_data_d;
         m_valid_q <= m_valid_d;
         m_last_q  <= m_last_d;
         busy_q    <= busy_d;
      end
   end

   assign m_valid = m_valid_q;
   assign m_data  = m_data_q;
   assign m_last  = m_last_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_lp_fifo_burst_drain.sv
// Directed bench for lp_fifo_burst_drain with a FIFO model and beat scoreboard.
// Follows LP_FIFO_BURST_DRAIN_TIMEOUT_EN to pick the timeout expectations.
`timescale 1ns/1ps
module tb_lp_fifo_burst_drain;

   localparam int WIDTH     = 8;
   localparam int CNT_WIDTH = 4;
   localparam int BURST_LEN = 4;
   localparam int TIMEOUT   = 16;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             last;
   } beat_t;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [WIDTH-1:0]     fifo_data_out = '0;
   logic [CNT_WIDTH-1:0] fifo_word_cnt = '0;
   logic                 fifo_empty = 1'b1;
   logic                 fifo_pop_n;
   logic                 m_valid;
   logic                 m_ready = 1'b0;
   logic [WIDTH-1:0]     m_data;
   logic                 m_last;
   logic                 busy;

   logic [WIDTH-1:0] fifo_q[$];
   logic [WIDTH-1:0] in_q[$];
   beat_t            sb[$];
   int               acc_cyc[$];
   int               cyc = 0;
   int               checks = 0;
   int               errors = 0;

   lp_fifo_burst_drain #(
      .WIDTH     (WIDTH),
      .CNT_WIDTH (CNT_WIDTH),
      .BURST_LEN (BURST_LEN),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .fifo_data_out (fifo_data_out),
      .fifo_word_cnt (fifo_word_cnt),
      .fifo_empty    (fifo_empty),
      .fifo_pop_n    (fifo_pop_n),
      .m_valid       (m_valid),
      .m_ready       (m_ready),
      .m_data        (m_data),
      .m_last        (m_last),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   // Dataflow FIFO model: pop sampled at the edge, then bulk pushes land
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!fifo_pop_n) begin
         checks++;
         assert ((fifo_q.size() > 0) === 1'b1) else begin
            errors++;
            $error("FAIL underflow obs=pop_on_empty exp=no_pop");
         end
         if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      end
      while (in_q.size() > 0) fifo_q.push_back(in_q.pop_front());
      fifo_data_out <= (fifo_q.size() > 0) ? fifo_q[0] : '0;
      fifo_word_cnt <= CNT_WIDTH'(fifo_q.size());
      fifo_empty    <= (fifo_q.size() == 0);
   end

   task automatic monitor();
      beat_t exp_b;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
            acc_cyc.push_back(cyc);
            checks++;
            assert ((sb.size() > 0) === 1'b1) else begin
               errors++;
               $error("FAIL extra_beat obs=%0h exp=none", m_data);
            end
            if (sb.size() > 0) begin
               exp_b = sb.pop_front();
               checks++;
               assert ({m_data, m_last} === exp_b) else begin
                  errors++;
                  $error("FAIL beat obs=%0h/%0b exp=%0h/%0b",
                         m_data, m_last, exp_b.data, exp_b.last);
               end
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [WIDTH-1:0] d, input logic last);
      in_q.push_back(d);
      sb.push_back({d, last});
   endtask

   task automatic wait_busy(input logic val, input int limit,
                            input string tag);
      int k;
      k = 0;
      while (busy !== val && k < limit) begin
         tick();
         k++;
      end
      chk(tag, {31'd0, busy}, {31'd0, val});
   endtask

   initial begin
      int t0;
      int k;
      int n0;
      fork
         monitor();
      join_none

      // Reset state
      tick(2);
      chk("rst_popn", {31'd0, fifo_pop_n}, 32'd1);
      chk("rst_valid", {31'd0, m_valid}, 32'd0);
      chk("rst_last", {31'd0, m_last}, 32'd0);
      chk("rst_data", {24'd0, m_data}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      tick();

      // Full burst
      m_ready = 1'b1;
      push(8'hA0, 1'b0);
      push(8'hA1, 1'b0);
      push(8'hA2, 1'b0);
      push(8'hA3, 1'b1);
      tick();
      t0 = cyc;
      wait_busy(1'b1, 10, "t1_busy_rise");
      chk("t1_start_lat", cyc - t0, 32'd1);
      wait_busy(1'b0, 20, "t1_busy_fall");
      chk("t1_busy_len", cyc - t0, 32'd6);
      chk("t1_nbeats", acc_cyc.size(), 32'd4);
      if (acc_cyc.size() >= 4)
         chk("t1_contig", acc_cyc[3] - acc_cyc[0], 32'd3);
      chk("t1_cnt", {28'd0, fifo_word_cnt}, 32'd0);
      chk("t1_sb", sb.size(), 32'd0);

      // Backpressure
      push(8'hB0, 1'b0);
      push(8'hB1, 1'b0);
      push(8'hB2, 1'b0);
      push(8'hB3, 1'b1);
      k = 0;
      while (m_valid !== 1'b1 && k < 10) begin
         tick();
         k++;
      end
      chk("t2_valid", {31'd0, m_valid}, 32'd1);
      m_ready = 1'b0;
      repeat (3) begin
         #1;
         chk("t2_hold", {24'd0, m_data}, 32'hB0);
         chk("t2_popn", {31'd0, fifo_pop_n}, 32'd1);
         tick();
      end
      chk("t2_cnt_held", {28'd0, fifo_word_cnt}, 32'd3);
      m_ready = 1'b1;
      wait_busy(1'b0, 20, "t2_done");
      chk("t2_sb", sb.size(), 32'd0);
      chk("t2_cnt", {28'd0, fifo_word_cnt}, 32'd0);

      // Timeout flush
`ifdef LP_FIFO_BURST_DRAIN_TIMEOUT_EN
      push(8'hC0, 1'b0);
      push(8'hC1, 1'b1);
      tick();
      t0 = cyc;
      wait_busy(1'b1, TIMEOUT + 10, "t3_flush_start");
      chk("t3_flush_lat", cyc - t0, TIMEOUT);
      wait_busy(1'b0, 20, "t3_flush_done");
      chk("t3_sb", sb.size(), 32'd0);
`else
      n0 = acc_cyc.size();
      push(8'hC0, 1'b0);
      push(8'hC1, 1'b0);
      tick(3 * TIMEOUT);
      chk("t3_no_busy", {31'd0, busy}, 32'd0);
      chk("t3_no_beats", acc_cyc.size() - n0, 32'd0);
      chk("t3_resid", {28'd0, fifo_word_cnt}, 32'd2);
      push(8'hC2, 1'b0);
      push(8'hC3, 1'b1);
      wait_busy(1'b1, 10, "t3_fill_start");
      wait_busy(1'b0, 20, "t3_fill_done");
      chk("t3_sb", sb.size(), 32'd0);
`endif

      // Growth: fifth word waits for the next burst
      push(8'hD0, 1'b0);
      push(8'hD1, 1'b0);
      push(8'hD2, 1'b0);
      push(8'hD3, 1'b1);
      push(8'hD4, 1'b0);
      wait_busy(1'b1, 10, "t4_start");
      wait_busy(1'b0, 20, "t4_done");
      chk("t4_left_sb", sb.size(), 32'd1);
      chk("t4_left_cnt", {28'd0, fifo_word_cnt}, 32'd1);
      push(8'hD5, 1'b0);
      push(8'hD6, 1'b0);
      push(8'hD7, 1'b1);
      wait_busy(1'b1, 10, "t4_start2");
      wait_busy(1'b0, 20, "t4_done2");
      chk("t4_sb", sb.size(), 32'd0);

      // Reset mid-burst
      n0 = acc_cyc.size();
      push(8'hE0, 1'b0);
      push(8'hE1, 1'b0);
      push(8'hE2, 1'b0);
      push(8'hE3, 1'b0);
      k = 0;
      while (acc_cyc.size() < n0 + 2 && k < 20) begin
         tick();
         k++;
      end
      chk("t5_two_beats", acc_cyc.size() - n0, 32'd2);
      rst_n = 1'b0;
      #1;
      chk("t5_popn_rst", {31'd0, fifo_pop_n}, 32'd1);
      chk("t5_valid_pre", {31'd0, m_valid}, 32'd1);
      void'(sb.pop_front());
      tick();
      chk("t5_valid_post", {31'd0, m_valid}, 32'd0);
      chk("t5_busy_post", {31'd0, busy}, 32'd0);
      chk("t5_cnt_post", {28'd0, fifo_word_cnt}, 32'd1);
      rst_n = 1'b1;
      push(8'hE4, 1'b0);
      push(8'hE5, 1'b0);
      push(8'hE6, 1'b1);
      wait_busy(1'b1, 10, "t5_restart");
      wait_busy(1'b0, 20, "t5_done");
      chk("t5_sb", sb.size(), 32'd0);

      // Back-to-back bursts
      n0 = acc_cyc.size();
      for (int i = 0; i < 8; i++) begin
         push(WIDTH'(8'hF0 + i), (i == 3) || (i == 7));
      end
      k = 0;
      while (acc_cyc.size() < n0 + 8 && k < 40) begin
         tick();
         k++;
      end
      chk("t6_nbeats", acc_cyc.size() - n0, 32'd8);
      if (acc_cyc.size() >= n0 + 8) begin
         chk("t6_burst1", acc_cyc[n0+3] - acc_cyc[n0], 32'd3);
         chk("t6_gap", acc_cyc[n0+4] - acc_cyc[n0+3], 32'd3);
         chk("t6_burst2", acc_cyc[n0+7] - acc_cyc[n0+4], 32'd3);
      end
      wait_busy(1'b0, 20, "t6_done");
      chk("t6_sb", sb.size(), 32'd0);
      chk("t6_cnt", {28'd0, fifo_word_cnt}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
